// File: rtl/regfile_scoreboard.sv
// Register file with write-through bypass plus a per-register pending-write scoreboard
// that tracks in-flight destination writes between issue and writeback.
package regfile_scoreboard_pkg;
    localparam int unsigned WB_XLEN     = 32;
    localparam int unsigned WB_IDX_BITS = 5;

    typedef struct packed {
        logic                   rd_we;
        logic [WB_IDX_BITS-1:0] rd_s;
        logic [WB_XLEN-1:0]     rd_v;
    } wb_id_t;
endpackage

module regfile_scoreboard #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned RF_IDX_BITS = 5,
    parameter int unsigned PEND_BITS   = 2
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  regfile_scoreboard_pkg::wb_id_t  wb_id_i,
    input  logic [RF_IDX_BITS-1:0]          rs1_s_i,
    input  logic [RF_IDX_BITS-1:0]          rs2_s_i,
    output logic [XLEN-1:0]                 rs1_v_o,
    output logic [XLEN-1:0]                 rs2_v_o,
    output logic                            rs1_busy_o,
    output logic                            rs2_busy_o,
    input  logic                            issue_valid_i,
    input  logic                            issue_rd_we_i,
    input  logic [RF_IDX_BITS-1:0]          issue_rd_s_i,
    output logic                            issue_ready_o,
    input  logic                            flush_i
);
    localparam int unsigned NREG = 2 ** RF_IDX_BITS;

    logic [XLEN-1:0]        regs     [NREG];
    logic [PEND_BITS-1:0]   pend     [NREG];
    logic [PEND_BITS-1:0]   pend_nxt [NREG];

    logic                   wb_we;
    logic [RF_IDX_BITS-1:0] wb_s;
    logic [XLEN-1:0]        wb_v;
    logic                   retire;
    logic                   accept;

    assign wb_we  = wb_id_i.rd_we;
    assign wb_s   = RF_IDX_BITS'(wb_id_i.rd_s);
    assign wb_v   = XLEN'(wb_id_i.rd_v);
    assign retire = wb_we & (wb_s != '0);
    assign accept = issue_valid_i & issue_ready_o & issue_rd_we_i & (issue_rd_s_i != '0);

    // Entry 0 is cleared by reset and never written, so it always reads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (retire) begin
            regs[wb_s] <= wb_v;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NREG); i++) pend[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) pend[i] <= pend_nxt[i];
        end
    end

    // Flush beats everything; a matched issue+retire cancels; retire saturates at zero.
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) pend_nxt[i] = pend[i];
        if (flush_i) begin
            for (int i = 0; i < int'(NREG); i++) pend_nxt[i] = '0;
        end else begin
            for (int i = 1; i < int'(NREG); i++) begin
                if (accept && (issue_rd_s_i == RF_IDX_BITS'(i)) &&
                    !(retire && (wb_s == RF_IDX_BITS'(i)))) begin
                    pend_nxt[i] = pend[i] + PEND_BITS'(1);
                end else if (retire && (wb_s == RF_IDX_BITS'(i)) &&
                             !(accept && (issue_rd_s_i == RF_IDX_BITS'(i))) &&
                             (pend[i] != '0)) begin
                    pend_nxt[i] = pend[i] - PEND_BITS'(1);
                end
            end
        end
    end

    always_comb begin
        rs1_v_o = (retire && (wb_s == rs1_s_i)) ? wb_v : regs[rs1_s_i];
        rs2_v_o = (retire && (wb_s == rs2_s_i)) ? wb_v : regs[rs2_s_i];
    end

    // Busy clears in the cycle the last outstanding write is being retired.
    always_comb begin
        rs1_busy_o = (rs1_s_i != '0) && (pend[rs1_s_i] != '0) &&
                     !(retire && (wb_s == rs1_s_i) && (pend[rs1_s_i] == PEND_BITS'(1)));
        rs2_busy_o = (rs2_s_i != '0) && (pend[rs2_s_i] != '0) &&
                     !(retire && (wb_s == rs2_s_i) && (pend[rs2_s_i] == PEND_BITS'(1)));
    end

    // Independent of issue_valid_i so decode can use it without a loop.
    assign issue_ready_o = !(issue_rd_we_i && (issue_rd_s_i != '0) && (&pend[issue_rd_s_i]));

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard: one task per scenario,
// inputs driven 1ns after the rising edge, outputs sampled mid-cycle.
module tb_regfile_scoreboard;
    logic                            clk;
    logic                            rst_n;
    regfile_scoreboard_pkg::wb_id_t  wb_id;
    logic [4:0]                      rs1_s;
    logic [4:0]                      rs2_s;
    logic [31:0]                     rs1_v;
    logic [31:0]                     rs2_v;
    logic                            rs1_busy;
    logic                            rs2_busy;
    logic                            issue_valid;
    logic                            issue_rd_we;
    logic [4:0]                      issue_rd_s;
    logic                            issue_ready;
    logic                            flush;

    int n_cmp = 0;
    int n_err = 0;

    regfile_scoreboard #(.XLEN(32), .RF_IDX_BITS(5), .PEND_BITS(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .wb_id_i       (wb_id),
        .rs1_s_i       (rs1_s),
        .rs2_s_i       (rs2_s),
        .rs1_v_o       (rs1_v),
        .rs2_v_o       (rs2_v),
        .rs1_busy_o    (rs1_busy),
        .rs2_busy_o    (rs2_busy),
        .issue_valid_i (issue_valid),
        .issue_rd_we_i (issue_rd_we),
        .issue_rd_s_i  (issue_rd_s),
        .issue_ready_o (issue_ready),
        .flush_i       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_id       = '0;
        issue_valid = 1'b0;
        issue_rd_we = 1'b0;
        issue_rd_s  = '0;
        flush       = 1'b0;
    endtask

    task automatic wb(input logic [4:0] s, input logic [31:0] v);
        wb_id.rd_we = 1'b1;
        wb_id.rd_s  = s;
        wb_id.rd_v  = v;
    endtask

    task automatic issue(input logic [4:0] s);
        issue_valid = 1'b1;
        issue_rd_we = 1'b1;
        issue_rd_s  = s;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        rs1_s = 5'd3;
        rs2_s = 5'd3;
        issue_rd_we = 1'b1;
        issue_rd_s  = 5'd3;
        #2;
        n_cmp++;
        if (rs1_v !== 32'h0) begin n_err++; $display("FAIL reset_rs1_v got %h exp %h", rs1_v, 32'h0); end
        n_cmp++;
        if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b exp 0", rs1_busy); end
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got %b exp 1", issue_ready); end
        step();
        step();
        rst_n = 1'b1;
        idle();
        step();
        n_cmp++;
        if (rs2_v !== 32'h0) begin n_err++; $display("FAIL post_reset_rs2_v got %h exp %h", rs2_v, 32'h0); end
    endtask

    task automatic test_write_read();
        idle();
        rs1_s = 5'd1;
        wb(5'd5, 32'hDEADBEEF);
        step();
        idle();
        rs1_s = 5'd5;
        #1;
        n_cmp++;
        if (rs1_v !== 32'hDEADBEEF) begin n_err++; $display("FAIL read_x5 got %h exp %h", rs1_v, 32'hDEADBEEF); end
        wb(5'd0, 32'h1234);
        rs1_s = 5'd0;
        #1;
        n_cmp++;
        if (rs1_v !== 32'h0) begin n_err++; $display("FAIL x0_no_bypass got %h exp %h", rs1_v, 32'h0); end
        step();
        idle();
        rs1_s = 5'd0;
        rs2_s = 5'd0;
        #1;
        n_cmp++;
        if (rs1_v !== 32'h0) begin n_err++; $display("FAIL x0_rs1 got %h exp %h", rs1_v, 32'h0); end
        n_cmp++;
        if (rs2_v !== 32'h0) begin n_err++; $display("FAIL x0_rs2 got %h exp %h", rs2_v, 32'h0); end
    endtask

    task automatic test_bypass();
        idle();
        rs1_s = 5'd7;
        rs2_s = 5'd7;
        wb(5'd7, 32'hA5A5A5A5);
        #1;
        n_cmp++;
        if (rs2_v !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_rs2 got %h exp %h", rs2_v, 32'hA5A5A5A5); end
        n_cmp++;
        if (rs1_v !== 32'hA5A5A5A5) begin n_err++; $display("FAIL bypass_rs1 got %h exp %h", rs1_v, 32'hA5A5A5A5); end
        step();
        idle();
        rs1_s = 5'd5;
        #1;
        n_cmp++;
        if (rs2_v !== 32'hA5A5A5A5) begin n_err++; $display("FAIL stored_x7 got %h exp %h", rs2_v, 32'hA5A5A5A5); end
        n_cmp++;
        if (rs1_v !== 32'hDEADBEEF) begin n_err++; $display("FAIL x5_kept got %h exp %h", rs1_v, 32'hDEADBEEF); end
    endtask

    task automatic test_saturate();
        idle();
        rs1_s = 5'd3;
        for (int k = 0; k < 3; k++) begin
            issue(5'd3);
            #1;
            n_cmp++;
            if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_ready_%0d got %b exp 1", k, issue_ready); end
            step();
        end
        idle();
        issue_rd_we = 1'b1;
        issue_rd_s  = 5'd3;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sat_ready_rd3 got %b exp 0", issue_ready); end
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sat_busy_rd3 got %b exp 1", rs1_busy); end
        issue_rd_s = 5'd4;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL sat_ready_rd4 got %b exp 1", issue_ready); end
        // Offer rd3 while full: must not wrap the counter.
        issue(5'd3);
        step();
        idle();
        // First writeback gives no same-cycle relief to ready.
        issue_rd_we = 1'b1;
        issue_rd_s  = 5'd3;
        wb(5'd3, 32'h33);
        #1;
        n_cmp++;
        if (issue_ready !== 1'b0) begin n_err++; $display("FAIL sat_no_relief got %b exp 0", issue_ready); end
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sat_busy_wb1 got %b exp 1", rs1_busy); end
        step();
        wb(5'd3, 32'h34);
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL sat_busy_wb2 got %b exp 1", rs1_busy); end
        step();
        wb(5'd3, 32'h35);
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL sat_busy_wb3 got %b exp 0", rs1_busy); end
        step();
        // Extra writeback at zero must not underflow.
        wb(5'd3, 32'h36);
        step();
        idle();
        issue_rd_we = 1'b1;
        issue_rd_s  = 5'd3;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL underflow_busy got %b exp 0", rs1_busy); end
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL underflow_ready got %b exp 1", issue_ready); end
        n_cmp++;
        if (rs1_v !== 32'h36) begin n_err++; $display("FAIL x3_value got %h exp %h", rs1_v, 32'h36); end
        idle();
    endtask

    task automatic test_back_to_back();
        idle();
        rs1_s = 5'd9;
        issue(5'd9);
        step();
        issue(5'd9);
        wb(5'd9, 32'h99);
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL simul_busy_same got %b exp 0", rs1_busy); end
        step();
        idle();
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1) begin n_err++; $display("FAIL simul_busy_next got %b exp 1", rs1_busy); end
        wb(5'd9, 32'h9A);
        step();
        idle();
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL simul_drain got %b exp 0", rs1_busy); end
    endtask

    task automatic test_flush();
        idle();
        issue(5'd2);
        step();
        issue(5'd2);
        step();
        issue(5'd6);
        step();
        idle();
        rs1_s = 5'd2;
        rs2_s = 5'd6;
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b1 || rs2_busy !== 1'b1) begin
            n_err++; $display("FAIL pre_flush_busy got %b%b exp 11", rs1_busy, rs2_busy);
        end
        flush = 1'b1;
        wb(5'd2, 32'h22222222);
        step();
        idle();
        #1;
        n_cmp++;
        if (rs1_busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_x2 got %b exp 0", rs1_busy); end
        n_cmp++;
        if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_x6 got %b exp 0", rs2_busy); end
        n_cmp++;
        if (rs1_v !== 32'h22222222) begin n_err++; $display("FAIL flush_write_x2 got %h exp %h", rs1_v, 32'h22222222); end
        wb(5'd6, 32'h66);
        step();
        idle();
        issue_rd_we = 1'b1;
        issue_rd_s  = 5'd6;
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL flush_late_wb got %b exp 0", rs2_busy); end
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL flush_late_ready got %b exp 1", issue_ready); end
        n_cmp++;
        if (rs2_v !== 32'h66) begin n_err++; $display("FAIL x6_value got %h exp %h", rs2_v, 32'h66); end
        idle();
    endtask

    task automatic test_reset_mid();
        idle();
        wb(5'd5, 32'h55);
        issue(5'd4);
        step();
        idle();
        issue(5'd4);
        step();
        issue(5'd4);
        step();
        idle();
        rs1_s = 5'd5;
        rs2_s = 5'd4;
        issue_rd_we = 1'b1;
        issue_rd_s  = 5'd4;
        #1;
        n_cmp++;
        if (issue_ready !== 1'b0 || rs2_busy !== 1'b1 || rs1_v !== 32'h55) begin
            n_err++; $display("FAIL pre_reset_state got ready=%b busy=%b v=%h exp 0 1 00000055", issue_ready, rs2_busy, rs1_v);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rs1_v !== 32'h0) begin n_err++; $display("FAIL mid_reset_v got %h exp %h", rs1_v, 32'h0); end
        n_cmp++;
        if (rs2_busy !== 1'b0) begin n_err++; $display("FAIL mid_reset_busy got %b exp 0", rs2_busy); end
        n_cmp++;
        if (issue_ready !== 1'b1) begin n_err++; $display("FAIL mid_reset_ready got %b exp 1", issue_ready); end
        // Issue presented in the release cycle counts at the first edge with reset high.
        issue(5'd4);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        idle();
        #1;
        n_cmp++;
        if (rs2_busy !== 1'b1) begin n_err++; $display("FAIL release_issue_busy got %b exp 1", rs2_busy); end
        n_cmp++;
        if (rs1_v !== 32'h0) begin n_err++; $display("FAIL release_x5 got %h exp %h", rs1_v, 32'h0); end
    endtask

    initial begin
        rs1_s = '0;
        rs2_s = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_saturate();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, register data width.
REQ-002 Parameter RF_IDX_BITS, default 5, register index width (2**RF_IDX_BITS registers).
REQ-003 Parameter PEND_BITS, default 2, width of each per-register pending-write counter.
REQ-004 Port clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 Port rst_ni  input  1  reset; asynchronous, active-low.
REQ-006 Port wb_id_i  input  wb_id_t  writeback request; fields rd_we, rd_s, rd_v.
REQ-007 Port rs1_s_i  input  RF_IDX_BITS  read port 1 index.
REQ-008 Port rs2_s_i  input  RF_IDX_BITS  read port 2 index.
REQ-009 Port rs1_v_o  output  XLEN  read port 1 data.
REQ-010 Port rs2_v_o  output  XLEN  read port 2 data.
REQ-011 Port rs1_busy_o  output  1  rs1 has an outstanding write not yet visible.
REQ-012 Port rs2_busy_o  output  1  rs2 has an outstanding write not yet visible.
REQ-013 Port issue_valid_i  input  1  decode offers an instruction for issue.
REQ-014 Port issue_rd_we_i  input  1  offered instruction writes a destination.
REQ-015 Port issue_rd_s_i  input  RF_IDX_BITS  offered instruction destination index.
REQ-016 Port issue_ready_o  output  1  scoreboard can record the offered instruction.
REQ-017 Port flush_i  input  1  pipeline squash; clears all pending counters.

Function
REQ-018 Register file: 2**RF_IDX_BITS entries of XLEN bits; index 0 always reads 0, is never written, never busy, never counted.
REQ-019 Write: at rising edge with wb_id_i.rd_we=1 and rd_s!=0, regs[rd_s] <= rd_v; independent of flush_i.
REQ-020 Read: combinational; rsN_v_o = regs[rsN_s_i], except when the same cycle's writeback targets rsN_s_i (non-zero, rd_we=1), then rsN_v_o = wb_id_i.rd_v (write-through bypass).
REQ-021 Pending counter pend[i], PEND_BITS wide, one per register i>=1.
REQ-022 Issue accept = issue_valid_i & issue_ready_o & issue_rd_we_i & (issue_rd_s_i!=0).
REQ-023 Writeback retire = wb_id_i.rd_we & (wb_id_i.rd_s!=0).
REQ-024 Counter update, priority order: flush_i=1 -> all pend <= 0; else accept and retire to same index -> unchanged; else accept -> +1; else retire -> -1, saturating at 0 (no underflow).
REQ-025 issue_ready_o = 0 iff issue_rd_we_i=1, issue_rd_s_i!=0 and pend[issue_rd_s_i] is all-ones (saturated); otherwise 1; no relief from a same-cycle retire.
REQ-026 rsN_busy_o = (rsN_s_i!=0) & (pend[rsN_s_i]!=0) & ~(retire to rsN_s_i this cycle & pend[rsN_s_i]==1).
REQ-027 Busy and ready are purely combinational from current state and inputs; zero-cycle latency; state changes visible the cycle after the edge.
REQ-028 issue_ready_o does not depend on issue_valid_i (no combinational loop to decode).

Reset
REQ-029 rst_ni low: all regs <= 0 and all pend <= 0 immediately, without clock.
REQ-030 During and after reset: rsN_v_o = 0, rsN_busy_o = 0, issue_ready_o = 1 until new state is written.
REQ-031 Writeback or issue arriving in the cycle rst_ni deasserts takes effect at the first rising edge with rst_ni high.

Verification
REQ-032 Write x5=0xDEADBEEF, next cycle read rs1_s_i=5 -> rs1_v_o=0xDEADBEEF; write x0=0x1234 -> reads of x0 return 0.
REQ-033 Same-cycle writeback x7=0xA5A5A5A5 and rs2_s_i=7 -> rs2_v_o=0xA5A5A5A5 in that cycle.
REQ-034 Issue rd=3 three times (pend=3) -> issue_ready_o=0 for rd=3, 1 for rd=4; rs1_s_i=3 busy=1; three writebacks to x3 -> busy drops in the cycle of the third writeback.
REQ-035 pend[9]=1, simultaneous issue rd=9 and writeback x9 -> pend stays 1, rs1_busy_o=1 next cycle.
REQ-036 pend[2]=2, pend[6]=1, flush_i=1 with writeback x2 -> all pend=0, x2 updated; later writeback x6 -> pend[6] stays 0.
REQ-037 Mid-operation rst_ni low between edges -> regs and counters zero immediately, busy=0, issue_ready_o=1.
